// File: rtl/xbar_ingress_port.sv
// Crossbar ingress port: accepts packets offered by the local core, stamps the
// source node, drops packets with an illegal destination (flagging dest_err),
// queues the rest in a small FIFO and presents the oldest entry as a request to
// the crossbar until it is granted.
//
// Packet layout (32 bits): [31:24] src, [23:16] dest, [15:0] memoryAddress.
// The dest field is 8 bits wide so out-of-range destinations can be detected.
module xbar_ingress_port #(
    parameter int NUM_PROC = 4,
    parameter int NODE_ID  = 0,
    parameter int DEPTH    = 4,
    localparam int DEST_W  = $clog2(NUM_PROC),
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int PKT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              packetCoreIn,
    input  logic [PKT_W-1:0]  packetSendIn,
    output logic              recievedOut,
    output logic              full,
    output logic              out_req,
    output logic [DEST_W-1:0] out_dest,
    output logic [PKT_W-1:0]  out_pkt,
    input  logic              out_grant,
    output logic [PTR_W:0]    occupancy,
    output logic [7:0]        stall_cnt,
    output logic              dest_err
);

    typedef enum logic {ST_EMPTY, ST_REQ} state_t;

    state_t            state_p0, state_nxt;
    logic [PKT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_p0, rd_ptr_p0;
    logic [PTR_W:0]    occ_p0;
    logic              accept, dest_ok, wr_en, pop;
    logic [PKT_W-1:0]  head;
    logic              unused_src;

    // Saturating increment for the stall counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The offered src field is replaced by NODE_ID, so it is never looked at.
    assign unused_src = ^packetSendIn[31:24];

    // A held offer is not re-sampled during its own acknowledge cycle, and a
    // full FIFO never accepts even if the head is popped on the same edge.
    assign accept  = packetCoreIn & ~recievedOut & ~full;
    assign dest_ok = {1'b0, packetSendIn[23:16]} < 9'(NUM_PROC);
    assign wr_en   = accept & dest_ok;
    assign pop     = (state_p0 == ST_REQ) & out_grant;
    assign full    = (occ_p0 == (PTR_W+1)'(DEPTH));
    assign occupancy = occ_p0;
    assign head    = mem[rd_ptr_p0];

    // Head FSM next state and request outputs; the head is zeroed while idle.
    always_comb begin
        state_nxt = state_p0;
        out_req   = 1'b0;
        out_pkt   = '0;
        out_dest  = '0;
        case (state_p0)
            ST_EMPTY: begin
                if (wr_en) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                out_req  = 1'b1;
                out_pkt  = head;
                out_dest = head[16 +: DEST_W];
                if (pop && !wr_en && occ_p0 == (PTR_W+1)'(1)) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // ---- stage p0: control state (FSM, pointers, occupancy, flags) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0    <= ST_EMPTY;
            wr_ptr_p0   <= '0;
            rd_ptr_p0   <= '0;
            occ_p0      <= '0;
            recievedOut <= 1'b0;
            stall_cnt   <= '0;
            dest_err    <= 1'b0;
        end else begin
            state_p0    <= state_nxt;
            recievedOut <= accept;
            if (wr_en) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            if (pop)   rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            case ({wr_en, pop})
                2'b10:   occ_p0 <= occ_p0 + 1'b1;
                2'b01:   occ_p0 <= occ_p0 - 1'b1;
                default: occ_p0 <= occ_p0;
            endcase
            if (accept && !dest_ok) dest_err <= 1'b1;
            if (state_p0 == ST_REQ && !out_grant) stall_cnt <= sat_inc8(stall_cnt);
            else                                  stall_cnt <= '0;
        end
    end

    // FIFO storage; src is stamped with this node's id on write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_p0] <= {8'(NODE_ID), packetSendIn[23:0]};
    end

endmodule

// File: tb/tb_xbar_ingress_port.sv
// Directed bench for xbar_ingress_port (NUM_PROC=4, NODE_ID=1, DEPTH=4).
module tb_xbar_ingress_port;

    logic        clk, rst, packetCoreIn, out_grant;
    logic [31:0] packetSendIn, out_pkt;
    logic        recievedOut, full, out_req, dest_err;
    logic [1:0]  out_dest;
    logic [2:0]  occupancy;
    logic [7:0]  stall_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int n_pops = 0;
    bit mon_en = 0;
    logic [31:0] exp_q[$];

    xbar_ingress_port #(.NUM_PROC(4), .NODE_ID(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .packetCoreIn(packetCoreIn), .packetSendIn(packetSendIn),
        .recievedOut(recievedOut), .full(full), .out_req(out_req), .out_dest(out_dest),
        .out_pkt(out_pkt), .out_grant(out_grant), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .dest_err(dest_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        core;
        logic [7:0]  dest;
        logic [15:0] addr;
        logic        grant;
        logic        e_recv;
        logic [2:0]  e_occ;
        logic        e_req;
        logic [1:0]  e_dest;
        logic [31:0] e_pkt;
        logic [7:0]  e_stall;
        logic        e_derr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Offer one packet and hold it until acknowledged (bounded).
    task automatic offer(input logic [7:0] dest, input logic [15:0] addr);
        bit got = 0;
        packetCoreIn = 1;
        packetSendIn = {8'hAA, dest, addr};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (recievedOut) begin got = 1; break; end
        end
        packetCoreIn = 0;
        if (!got) fail_now("offer_ack");
        else if (dest < 8'd4) exp_q.push_back({8'h01, dest, addr});
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!out_req) begin done = 1; break; end
            @(posedge clk); #1;
        end
        if (!done) fail_now("drain");
    endtask

    // Order scoreboard: inputs only change just after a rising edge, so a
    // request+grant seen on the falling edge is a pop on the next rising edge.
    always @(negedge clk) begin
        if (mon_en && out_req && out_grant) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h expected none", out_pkt);
            end else begin
                chk("pop_order", out_pkt, exp_q.pop_front());
            end
        end
    end

    initial begin
        vec_t vt[12];
        int   p0;
        vt[0]  = '{1, 8'd2, 16'h1234, 0, 1, 3'd1, 1, 2'd2, 32'h0102_1234, 8'd0, 0};
        vt[1]  = '{1, 8'd2, 16'h1234, 0, 0, 3'd1, 1, 2'd2, 32'h0102_1234, 8'd1, 0};
        vt[2]  = '{0, 8'd0, 16'h0000, 1, 0, 3'd0, 0, 2'd0, 32'h0,         8'd0, 0};
        vt[3]  = '{0, 8'd0, 16'h0000, 1, 0, 3'd0, 0, 2'd0, 32'h0,         8'd0, 0};
        vt[4]  = '{1, 8'd7, 16'hBEEF, 0, 1, 3'd0, 0, 2'd0, 32'h0,         8'd0, 1};
        vt[5]  = '{0, 8'd0, 16'h0000, 0, 0, 3'd0, 0, 2'd0, 32'h0,         8'd0, 1};
        vt[6]  = '{1, 8'd1, 16'h0001, 0, 1, 3'd1, 1, 2'd1, 32'h0101_0001, 8'd0, 1};
        vt[7]  = '{1, 8'd3, 16'h0002, 0, 0, 3'd1, 1, 2'd1, 32'h0101_0001, 8'd1, 1};
        vt[8]  = '{1, 8'd3, 16'h0002, 0, 1, 3'd2, 1, 2'd1, 32'h0101_0001, 8'd2, 1};
        vt[9]  = '{1, 8'd0, 16'h0003, 1, 0, 3'd1, 1, 2'd3, 32'h0103_0002, 8'd0, 1};
        vt[10] = '{1, 8'd0, 16'h0003, 1, 1, 3'd1, 1, 2'd0, 32'h0100_0003, 8'd0, 1};
        vt[11] = '{0, 8'd0, 16'h0000, 1, 0, 3'd0, 0, 2'd0, 32'h0,         8'd0, 1};

        rst = 1; packetCoreIn = 0; packetSendIn = 0; out_grant = 0;
        #1;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_req", 32'(out_req), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_recv", 32'(recievedOut), 0);
        @(posedge clk); #1;
        rst = 0;

        // Table: first row hits the first edge after reset release.
        for (int i = 0; i < 12; i++) begin
            packetCoreIn = vt[i].core;
            packetSendIn = {8'hAA, vt[i].dest, vt[i].addr};
            out_grant    = vt[i].grant;
            @(posedge clk); #1;
            chk($sformatf("v%0d_recv", i),  32'(recievedOut), 32'(vt[i].e_recv));
            chk($sformatf("v%0d_occ", i),   32'(occupancy),   32'(vt[i].e_occ));
            chk($sformatf("v%0d_req", i),   32'(out_req),     32'(vt[i].e_req));
            chk($sformatf("v%0d_dest", i),  32'(out_dest),    32'(vt[i].e_dest));
            chk($sformatf("v%0d_pkt", i),   out_pkt,          vt[i].e_pkt);
            chk($sformatf("v%0d_stall", i), 32'(stall_cnt),   32'(vt[i].e_stall));
            chk($sformatf("v%0d_derr", i),  32'(dest_err),    32'(vt[i].e_derr));
        end
        packetCoreIn = 0; out_grant = 0;
        mon_en = 1;

        // Fill to full, fifth offer must wait until a pop frees space.
        p0 = n_pops;
        for (int i = 1; i <= 4; i++) offer(8'(i % 4), 16'h0100 + 16'(i));
        chk("full_flag", 32'(full), 1);
        chk("full_occ", 32'(occupancy), 4);
        packetCoreIn = 1; packetSendIn = {8'hAA, 8'd1, 16'h0105};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("full_noack", 32'(recievedOut), 0);
        end
        out_grant = 1;
        offer(8'd1, 16'h0105);
        wait_empty();
        out_grant = 0;
        chk("full_pops", 32'(n_pops - p0), 5);
        chk("full_q", 32'(exp_q.size()), 0);

        // Long stall saturates, a grant clears it.
        offer(8'd2, 16'h0200);
        repeat (300) @(posedge clk);
        #1;
        chk("stall_sat", 32'(stall_cnt), 255);
        out_grant = 1;
        @(posedge clk); #1;
        chk("stall_clr", 32'(stall_cnt), 0);
        chk("stall_occ", 32'(occupancy), 0);
        out_grant = 0;

        // Write and pop on the same edge keep occupancy.
        offer(8'd3, 16'h0301);
        offer(8'd0, 16'h0302);
        chk("sim_occ_pre", 32'(occupancy), 2);
        @(posedge clk); #1;
        packetCoreIn = 1; packetSendIn = {8'hAA, 8'd2, 16'h0303};
        exp_q.push_back(32'h0102_0303);
        out_grant = 1;
        @(posedge clk); #1;
        chk("sim_recv", 32'(recievedOut), 1);
        chk("sim_occ", 32'(occupancy), 2);
        packetCoreIn = 0;
        wait_empty();
        out_grant = 0;

        // Ten packets through four entries: pointers wrap.
        p0 = n_pops;
        out_grant = 1;
        for (int i = 0; i < 10; i++) offer(8'(i % 4), 16'h1000 + 16'(i));
        wait_empty();
        out_grant = 0;
        chk("wrap_pops", 32'(n_pops - p0), 10);
        chk("wrap_q", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-operation with an acknowledge pending.
        offer(8'd1, 16'h2001);
        offer(8'd2, 16'h2002);
        offer(8'd3, 16'h2003);
        chk("ar_occ_pre", 32'(occupancy), 3);
        #2 rst = 1;
        #1;
        chk("ar_occ", 32'(occupancy), 0);
        chk("ar_recv", 32'(recievedOut), 0);
        chk("ar_req", 32'(out_req), 0);
        chk("ar_full", 32'(full), 0);
        chk("ar_stall", 32'(stall_cnt), 0);
        chk("ar_derr", 32'(dest_err), 0);
        chk("ar_pkt", out_pkt, 0);
        chk("ar_dest", 32'(out_dest), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        packetCoreIn = 1; packetSendIn = {8'hAA, 8'd2, 16'h3000};
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(recievedOut), 1);
        chk("post_rst_occ", 32'(occupancy), 1);
        exp_q.push_back(32'h0102_3000);
        packetCoreIn = 0;
        out_grant = 1;
        wait_empty();
        out_grant = 0;
        chk("post_rst_q", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
